// File: rtl/jtag_user_pkg.sv
// Shared constants for the JTAG user-register function controller:
// sequencer state encoding, function-code layout and the NOP code.
package jtag_user_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Register-number field value meaning "no function selected".
  localparam int NOP_CODE = 0;

  // The mode bit (1 = shift-only, 0 = capture) is the MSB of the code.
  function automatic int mode_bit(input int ir_w);
    return ir_w - 1;
  endfunction

endpackage

// File: rtl/jtag_func_ir.sv
// USER1 function-code shift register: LSB-first shift, readback of the active
// code on capture, and a bit counter that qualifies each update.
module jtag_func_ir import jtag_user_pkg::*; #(
  parameter int IR_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sel,
  input  logic            tdi,
  input  logic            shift,
  input  logic            capture,
  input  logic            update,
  input  logic [IR_W-1:0] func,
  output logic [IR_W-1:0] code,
  output logic            tdo,
  output logic            new_code,
  output logic            len_err
);

  localparam int CW = $clog2(IR_W + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(IR_W);
  localparam logic [CW-1:0] CNT_SAT  = CW'(IR_W + 1);

  logic [IR_W-1:0] ir_sr;
  logic [CW-1:0]   ir_cnt;

  // Capture wins over shift when both are sampled high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_sr  <= '0;
      ir_cnt <= '0;
    end else if (sel) begin
      if (capture) begin
        ir_sr  <= func;
        ir_cnt <= '0;
      end else if (shift) begin
        ir_sr <= {tdi, ir_sr[IR_W-1:1]};
        if (ir_cnt != CNT_SAT) ir_cnt <= ir_cnt + CW'(1);
      end
    end
  end

  // Saturating at IR_W+1 keeps over-long shifts distinguishable from exact ones.
  assign code     = ir_sr;
  assign tdo      = ir_sr[0];
  assign new_code = sel & update & (ir_cnt == CNT_FULL);
  assign len_err  = sel & update & (ir_cnt != CNT_FULL);

endmodule

// File: rtl/jtag_user_func_ctrl.sv
// Function-select controller: decodes the USER1 code, sequences the selected
// USER2 capture/shift register and muxes its serial data back to TDO.
module jtag_user_func_ctrl import jtag_user_pkg::*; #(
  parameter int NREG    = 8,
  parameter int IR_W    = 8,
  parameter int ONESHOT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             DRCK,
  input  logic             RST,
  input  logic             SEL1,
  input  logic             SEL2,
  input  logic             TDI,
  input  logic             SHIFT,
  input  logic             CAPTURE,
  input  logic             UPDATE,
  input  logic [NREG-1:0]  REG_TDO,
  output logic             FSH,
  output logic             FCAP,
  output logic [NREG-1:0]  REG_SEL,
  output logic             TDO,
  output logic [IR_W-1:0]  FUNC,
  output logic [CNT_W-1:0] BITCNT,
  output logic             ERR
);

  localparam int NUM_W    = IR_W - 1;
  localparam int MODE_POS = mode_bit(IR_W);

  logic [IR_W-1:0]  ir_code;
  logic             ir_tdo;
  logic             new_code;
  logic             len_err;
  logic [1:0]       state;
  logic [NUM_W-1:0] func_num;
  logic [NUM_W-1:0] code_num;
  logic             func_valid;
  logic             code_valid;
  logic             sel2_only;

  function automatic logic num_valid(input logic [NUM_W-1:0] n);
    return (n != NUM_W'(NOP_CODE)) && (n <= NUM_W'(NREG));
  endfunction

  jtag_func_ir #(.IR_W(IR_W)) u_ir (
    .clk      (DRCK),
    .rst      (RST),
    .sel      (SEL1),
    .tdi      (TDI),
    .shift    (SHIFT),
    .capture  (CAPTURE),
    .update   (UPDATE),
    .func     (FUNC),
    .code     (ir_code),
    .tdo      (ir_tdo),
    .new_code (new_code),
    .len_err  (len_err)
  );

  assign func_num   = FUNC[NUM_W-1:0];
  assign code_num   = ir_code[NUM_W-1:0];
  assign func_valid = num_valid(func_num);
  assign code_valid = num_valid(code_num);
  // USER1 has priority: USER2 activity is ignored whenever SEL1 is high.
  assign sel2_only  = SEL2 & ~SEL1;

  assign FSH  = func_valid & FUNC[MODE_POS];
  assign FCAP = func_valid & ~FUNC[MODE_POS];

  // A USER1 update always redirects the sequencer, whatever it was doing.
  always_ff @(posedge DRCK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      FUNC  <= '0;
    end else if (new_code) begin
      FUNC  <= ir_code;
      state <= code_valid ? ARMED : IDLE;
    end else if (len_err) begin
      FUNC  <= '0;
      state <= IDLE;
    end else begin
      case (state)
        ARMED: if (sel2_only && (CAPTURE || SHIFT)) state <= DATA;
        DATA:  if (sel2_only && UPDATE) state <= DONE;
        DONE: begin
          if (ONESHOT != 0) begin
            state <= IDLE;
            FUNC  <= '0;
          end else begin
            state <= ARMED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge DRCK or posedge RST) begin
    if (RST) begin
      BITCNT <= '0;
    end else if (sel2_only && func_valid) begin
      if (CAPTURE) begin
        BITCNT <= '0;
      end else if (SHIFT && (state == ARMED || state == DATA) && BITCNT != '1) begin
        BITCNT <= BITCNT + CNT_W'(1);
      end
    end
  end

  // Sticky: bad length, out-of-range code, or both chains selected at once.
  always_ff @(posedge DRCK or posedge RST) begin
    if (RST) begin
      ERR <= 1'b0;
    end else if (len_err || (new_code && !code_valid && code_num != NUM_W'(NOP_CODE)) ||
                 (SEL1 && SEL2)) begin
      ERR <= 1'b1;
    end
  end

  always_comb begin
    REG_SEL = '0;
    for (int i = 0; i < NREG; i++) begin
      REG_SEL[i] = sel2_only && func_valid && (func_num == NUM_W'(i + 1));
    end
  end

  assign TDO = SEL1 ? ir_tdo : |(REG_TDO & REG_SEL);

endmodule

// File: tb/tb_jtag_user_func_ctrl.sv
// Bench for jtag_user_func_ctrl: a continuous-mode and a one-shot instance
// share stimulus and are compared every cycle against a behavioural model.
module tb_jtag_user_func_ctrl;

  localparam int NREG  = 8;
  localparam int IR_W  = 8;
  localparam int CNT_W = 16;

  typedef enum int {P_IDLE, P_ARMED, P_DATA, P_DONE} phase_t;

  logic            DRCK = 1'b0;
  logic            RST = 1'b1;
  logic            SEL1 = 1'b0, SEL2 = 1'b0, TDI = 1'b0;
  logic            SHIFT = 1'b0, CAPTURE = 1'b0, UPDATE = 1'b0;
  logic [NREG-1:0] REG_TDO = '0;

  logic             fsh [2];
  logic             fcap [2];
  logic             tdo [2];
  logic             err [2];
  logic [NREG-1:0]  reg_sel [2];
  logic [IR_W-1:0]  func [2];
  logic [CNT_W-1:0] bitcnt [2];

  int n_cmp = 0;
  int n_mis = 0;

  // model state, one slot per instance (0 = continuous, 1 = one-shot)
  int     m_func [2];
  int     m_ir [2];
  int     m_cnt [2];
  int     m_bit [2];
  bit     m_err [2];
  phase_t m_ph [2];

  jtag_user_func_ctrl #(.NREG(NREG), .IR_W(IR_W), .ONESHOT(0), .CNT_W(CNT_W)) u_cont (
    .DRCK(DRCK), .RST(RST), .SEL1(SEL1), .SEL2(SEL2), .TDI(TDI), .SHIFT(SHIFT),
    .CAPTURE(CAPTURE), .UPDATE(UPDATE), .REG_TDO(REG_TDO), .FSH(fsh[0]), .FCAP(fcap[0]),
    .REG_SEL(reg_sel[0]), .TDO(tdo[0]), .FUNC(func[0]), .BITCNT(bitcnt[0]), .ERR(err[0])
  );

  jtag_user_func_ctrl #(.NREG(NREG), .IR_W(IR_W), .ONESHOT(1), .CNT_W(CNT_W)) u_once (
    .DRCK(DRCK), .RST(RST), .SEL1(SEL1), .SEL2(SEL2), .TDI(TDI), .SHIFT(SHIFT),
    .CAPTURE(CAPTURE), .UPDATE(UPDATE), .REG_TDO(REG_TDO), .FSH(fsh[1]), .FCAP(fcap[1]),
    .REG_SEL(reg_sel[1]), .TDO(tdo[1]), .FUNC(func[1]), .BITCNT(bitcnt[1]), .ERR(err[1])
  );

  always #5 DRCK = ~DRCK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int num_of(input int f);
    return f & 'h7f;
  endfunction

  function automatic bit valid_of(input int f);
    return num_of(f) >= 1 && num_of(f) <= NREG;
  endfunction

  task automatic model_reset(input int j);
    m_func[j] = 0; m_ir[j] = 0; m_cnt[j] = 0; m_bit[j] = 0;
    m_err[j] = 1'b0; m_ph[j] = P_IDLE;
  endtask

  // One DRCK edge worth of the chain rules, applied to pre-edge values.
  task automatic model_step(input int j, input bit oneshot);
    int     nf, nir, ncnt, nb;
    bit     ne;
    phase_t np;
    bit     s2e;
    nf = m_func[j]; nir = m_ir[j]; ncnt = m_cnt[j]; nb = m_bit[j];
    ne = m_err[j]; np = m_ph[j];
    s2e = SEL2 && !SEL1;
    if (SEL1) begin
      if (CAPTURE) begin
        nir = m_func[j]; ncnt = 0;
      end else if (SHIFT) begin
        nir = (m_ir[j] >> 1) | (int'(TDI) << (IR_W - 1));
        ncnt = (m_cnt[j] + 1 > IR_W + 1) ? IR_W + 1 : m_cnt[j] + 1;
      end
    end
    if (SEL1 && UPDATE) begin
      if (m_cnt[j] == IR_W) begin
        nf = m_ir[j];
        if (valid_of(m_ir[j])) np = P_ARMED;
        else begin
          np = P_IDLE;
          if (num_of(m_ir[j]) != 0) ne = 1'b1;
        end
      end else begin
        nf = 0; ne = 1'b1; np = P_IDLE;
      end
    end else if (m_ph[j] == P_DONE) begin
      np = oneshot ? P_IDLE : P_ARMED;
      if (oneshot) nf = 0;
    end else if (m_ph[j] == P_ARMED && s2e && (CAPTURE || SHIFT)) begin
      np = P_DATA;
    end else if (m_ph[j] == P_DATA && s2e && UPDATE) begin
      np = P_DONE;
    end
    if (SEL1 && SEL2) ne = 1'b1;
    if (s2e && valid_of(m_func[j])) begin
      if (CAPTURE) nb = 0;
      else if (SHIFT && (m_ph[j] == P_ARMED || m_ph[j] == P_DATA) && m_bit[j] < 65535) nb = m_bit[j] + 1;
    end
    m_func[j] = nf; m_ir[j] = nir; m_cnt[j] = ncnt; m_bit[j] = nb;
    m_err[j] = ne; m_ph[j] = np;
  endtask

  task automatic check_outputs(input int j);
    bit v;
    int n;
    int exp_sel, exp_tdo;
    string p;
    v = valid_of(m_func[j]);
    n = num_of(m_func[j]);
    p = $sformatf("i%0d.", j);
    exp_sel = 0;
    exp_tdo = 0;
    if (SEL2 && !SEL1 && v) exp_sel = 1 << (n - 1);
    if (SEL1) exp_tdo = m_ir[j] & 1;
    else if (SEL2 && v) exp_tdo = int'(REG_TDO[n - 1]);
    check({p, "func"}, 32'(func[j]), 32'(m_func[j]));
    check({p, "fsh"}, 32'(fsh[j]), 32'(v && (m_func[j] & 'h80) != 0));
    check({p, "fcap"}, 32'(fcap[j]), 32'(v && (m_func[j] & 'h80) == 0));
    check({p, "reg_sel"}, 32'(reg_sel[j]), 32'(exp_sel));
    check({p, "tdo"}, 32'(tdo[j]), 32'(exp_tdo));
    check({p, "bitcnt"}, 32'(bitcnt[j]), 32'(m_bit[j]));
    check({p, "err"}, 32'(err[j]), 32'(m_err[j]));
  endtask

  task automatic cycle(input logic s1, s2, d, sh, cap, upd);
    @(negedge DRCK);
    SEL1 = s1; SEL2 = s2; TDI = d; SHIFT = sh; CAPTURE = cap; UPDATE = upd;
    REG_TDO = NREG'($urandom);
    @(posedge DRCK);
    model_step(0, 1'b0);
    model_step(1, 1'b1);
    #1;
    check_outputs(0);
    check_outputs(1);
  endtask

  // Reset is raised with the current inputs held so combinational drops show.
  task automatic do_reset();
    @(negedge DRCK);
    RST = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    check("rst.func", 32'(func[0]), 32'h0);
    check("rst.reg_sel", 32'(reg_sel[0]), 32'h0);
    check("rst.tdo", 32'(tdo[0]), 32'h0);
    check("rst.bitcnt", 32'(bitcnt[0]), 32'h0);
    check("rst.err", 32'(err[0]), 32'h0);
    check_outputs(0);
    check_outputs(1);
    @(negedge DRCK);
    RST = 1'b0;
    SEL1 = 0; SEL2 = 0; TDI = 0; SHIFT = 0; CAPTURE = 0; UPDATE = 0;
  endtask

  task automatic user1_load(input logic [IR_W-1:0] code, input int nbits);
    logic [15:0] bits;
    bits = {8'h00, code};
    cycle(1, 0, 0, 0, 1, 0);
    for (int i = 0; i < nbits; i++) cycle(1, 0, bits[i], 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [IR_W-1:0] rb;
    int low, nb;
    model_reset(0);
    model_reset(1);
    #1;
    check("init.func", 32'(func[0]), 32'h0);
    check("init.err", 32'(err[0]), 32'h0);
    check_outputs(0);
    check_outputs(1);
    @(negedge DRCK);
    RST = 1'b0;

    // capture-mode code selects register 2
    user1_load(8'h03, 8);
    check("c03.func", 32'(func[0]), 32'h03);
    check("c03.fcap", 32'(fcap[0]), 32'h1);
    check("c03.fsh", 32'(fsh[0]), 32'h0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, 0, 0, 0);
      check("c03.reg_sel", 32'(reg_sel[0]), 32'h04);
      check("c03.tdo", 32'(tdo[0]), 32'(REG_TDO[2]));
    end

    // shift-only code, 20-bit data access, then readback
    user1_load(8'h83, 8);
    check("c83.fsh", 32'(fsh[0]), 32'h1);
    check("c83.fcap", 32'(fcap[0]), 32'h0);
    cycle(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) cycle(0, 1, 1'($urandom), 1, 0, 0);
    check("c83.bitcnt", 32'(bitcnt[0]), 32'd20);
    check("c83.bitcnt1", 32'(bitcnt[1]), 32'd20);
    cycle(0, 1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0);
    rb[0] = tdo[0];
    for (int i = 1; i < IR_W; i++) begin
      cycle(1, 0, 0, 1, 0, 0);
      rb[i] = tdo[0];
    end
    check("c83.readback", 32'(rb), 32'h83);

    // short shift is a length error
    do_reset();
    user1_load(8'h05, 7);
    check("len.func", 32'(func[0]), 32'h0);
    check("len.err", 32'(err[0]), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 1, 0, 0);
      check("len.reg_sel", 32'(reg_sel[0]), 32'h0);
    end
    check("len.err_sticky", 32'(err[0]), 32'h1);
    do_reset();
    check("len.err_clr", 32'(err[0]), 32'h0);

    // out-of-range register number
    user1_load(8'h0A, 8);
    check("inv.err", 32'(err[0]), 32'h1);
    check("inv.fsh", 32'(fsh[0]), 32'h0);
    check("inv.fcap", 32'(fcap[0]), 32'h0);
    cycle(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 1'($urandom), 1, 0, 0);
      check("inv.tdo", 32'(tdo[0]), 32'h0);
    end

    // one-shot instance drops its code after one data access
    do_reset();
    user1_load(8'h01, 8);
    cycle(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 1'($urandom), 1, 0, 0);
    cycle(0, 1, 0, 0, 0, 1);
    check("os.func_upd", 32'(func[1]), 32'h01);
    cycle(0, 0, 0, 0, 0, 0);
    check("os.func_after", 32'(func[1]), 32'h00);
    cycle(0, 1, 0, 0, 1, 0);
    check("os.reg_sel", 32'(reg_sel[1]), 32'h0);
    check("os.reg_sel_cont", 32'(reg_sel[0]), 32'h01);

    // both chains selected, then reset mid-shift
    do_reset();
    user1_load(8'h02, 8);
    cycle(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1'($urandom), 1, 0, 0);
    cycle(1, 1, 0, 1, 0, 0);
    check("both.reg_sel", 32'(reg_sel[0]), 32'h0);
    check("both.err", 32'(err[0]), 32'h1);
    check("both.bitcnt", 32'(bitcnt[0]), 32'd3);
    cycle(0, 1, 1, 1, 0, 0);
    do_reset();

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      if ($urandom_range(0, 14) == 0) begin
        low = $urandom_range(0, 10);
        nb = ($urandom_range(0, 4) == 0) ? $urandom_range(7, 9) : 8;
        user1_load({1'($urandom), 7'(low)}, nb);
      end else begin
        cycle($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, 1'($urandom),
              1'($urandom), $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
